seg_display_scan: RTL
=====================

Name: seg_display_scan

Overview:
- Downstream consumer of the single-cycle CPU top's debug buses (curPC, nextPC, rsData, rtData, ALUresult, DBdata).
- Multiplexes one selected byte pair onto the board's 4-digit common-anode seven-segment display.
- Produces the anode-select (ctrlBits) and segment (dispcode) outputs.
- Refresh prescaler, digit scan counter, anti-ghost blanking and a per-frame data snapshot, so the display never tears mid-frame.

Parameters:
- SCAN_DIV, 100000: SYS_CLK cycles per digit slot; legal values 4 and up.
- BLANK_CYC, 2: cycles all anodes stay off at the start of each digit slot; legal range 1 to SCAN_DIV-1.

Ports:
- SYS_CLK  input  1  system clock; single clock domain.
- RST  input  1  asynchronous, active-low reset.
- SW_in  input  2  display select.
- curPC  input  32  current PC.
- nextPC  input  32  next PC.
- rsData  input  32  rs register read data.
- rtData  input  32  rt register read data.
- ALUresult  input  32  ALU output.
- DBdata  input  32  write-back data bus.
- ctrlBits  output  4  anode enables, active-low; bit3 is the leftmost digit.
- dispcode  output  8  segments, active-low; bit7=a … bit1=g, bit0=dp.

Behaviour:
- Reset (RST=0), asynchronous, takes effect with no clock edge required:
  - ctrlBits=4'b1111, dispcode=8'hFF.
  - Prescaler=0, digit index=3, snapshot registers=0, phase=BLANK.
- Prescaler:
  - Counts 0..SCAN_DIV-1, wraps to 0.
  - tick is asserted on the edge where count==SCAN_DIV-1.
- On each tick edge:
  - Digit index advances 3→0→1→2→3 (2-bit wrap).
  - Phase enters BLANK.
  - When the index goes 3→0, including the first tick after reset, latch the snapshot: sel←SW_in, L←left byte, R←right byte.
- Byte selection by sel:
  - 00: L=curPC[7:0], R=nextPC[7:0].
  - 01: L=rsData[7:0], R=rtData[7:0].
  - 10: L=ALUresult[7:0], R=DBdata[7:0].
  - 11: L=curPC[7:0], R=ALUresult[7:0].
- BLANK phase:
  - ctrlBits=1111, dispcode=FF.
  - Lasts exactly BLANK_CYC cycles.
  - Then enters SHOW on the edge BLANK_CYC cycles after the tick.
- SHOW phase drives the current digit; outputs are registered:
  - index 0: ctrlBits=1110, nibble R[3:0].
  - index 1: ctrlBits=1101, nibble R[7:4].
  - index 2: ctrlBits=1011, nibble L[3:0].
  - index 3: ctrlBits=0111, nibble L[7:4].
- Exactly one anode is low in SHOW; none in BLANK or reset.
- Hex decode for dispcode (dp always off, bit0=1):
  - 0:03, 1:9F, 2:25, 3:0D, 4:99, 5:49, 6:41, 7:1F
  - 8:01, 9:09, A:11, b:C1, C:63, d:85, E:61, F:71
- Stability rules:
  - Input changes, including SW_in, between frame starts never affect the current frame.
  - They appear only after the next 3→0 transition.
  - Snapshot data is constant through all four slots of a frame.
- Slot timing: one digit slot = SCAN_DIV cycles, split as BLANK_CYC blank followed by SCAN_DIV-BLANK_CYC show; one frame = 4×SCAN_DIV cycles.
- After reset release:
  - Outputs stay 1111/FF until the first tick (SCAN_DIV edges) plus BLANK_CYC cycles.
  - First digit shown is index 0 with the freshly captured snapshot.
- Reset mid-slot or mid-frame: immediate return to reset values; the scan restarts from the reset state.

Test Plan (SCAN_DIV=4, BLANK_CYC=1):
- Hold RST=0 for 10 clocks with all buses 0xFFFFFFFF -> ctrlBits=1111 and dispcode=FF throughout. Release RST -> still 1111/FF for 4+1 edges.
- SW_in=00, curPC=0x00000004, nextPC=0x00000008 -> show sequence is:
  - 1110/01
  - 1101/03
  - 1011/99
  - 0111/03
  - each show lasts 3 cycles, separated by 1 cycle of 1111/FF, then the sequence repeats.
- SW_in=10, ALUresult=0x000000AB, DBdata=0x000000CD -> digit0 85 (d), digit1 63 (C), digit2 C1 (b), digit3 11 (A).
- Change SW_in 00→01 and rsData=0x12 while digit1 is showing -> digits 2 and 3 still show curPC nibbles; the new selection appears from the next digit0.
- Pull RST low during the SHOW of digit2, asynchronously between clock edges -> ctrlBits=1111 and dispcode=FF before the next edge. After release, the first shown digit is index 0.
- Count cycles over 3 frames -> anode low period = 3, blank = 1, frame = 16, with no slot showing two anodes low.

Source files
------------

// File: rtl/seg_display_scan_if.sv
// Debug-bus bundle between the single-cycle CPU top and the seven-segment scanner.
// The CPU/bench side drives the buses as master; the display block is the slave.
interface seg_display_scan_if;
  logic [1:0]  SW_in;
  logic [31:0] curPC;
  logic [31:0] nextPC;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [31:0] ALUresult;
  logic [31:0] DBdata;
  logic [3:0]  ctrlBits;
  logic [7:0]  dispcode;

  modport master (
    output SW_in, curPC, nextPC, rsData, rtData, ALUresult, DBdata,
    input  ctrlBits, dispcode
  );

  modport slave (
    input  SW_in, curPC, nextPC, rsData, rtData, ALUresult, DBdata,
    output ctrlBits, dispcode
  );
endinterface

// File: rtl/seg_display_scan.sv
// Four-digit common-anode scanner: prescaled digit slots, a blanking gap at the start
// of every slot, and a byte-pair snapshot taken once per frame so a frame never tears.
module seg_display_scan #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic               SYS_CLK,
  input  logic               RST,
  seg_display_scan_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC - 1);

  // PH_WAIT is the blank period between reset release and the first tick.
  typedef enum logic [1:0] {
    PH_WAIT,
    PH_BLANK,
    PH_SHOW
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [1:0]       sel_q, sel_d;
  logic [7:0]       l_q, l_d;
  logic [7:0]       r_q, r_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [7:0]       seg_q, seg_d;

  logic       tick;
  logic [7:0] left_byte, right_byte;
  logic [3:0] nibble;

  // Only the low byte of each bus reaches the display.
  logic unused_hi_bytes;
  assign unused_hi_bytes = ^{bus.curPC[31:8], bus.nextPC[31:8], bus.rsData[31:8],
                             bus.rtData[31:8], bus.ALUresult[31:8], bus.DBdata[31:8]};

  function automatic logic [7:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 8'h03;
      4'h1: hex7 = 8'h9F;
      4'h2: hex7 = 8'h25;
      4'h3: hex7 = 8'h0D;
      4'h4: hex7 = 8'h99;
      4'h5: hex7 = 8'h49;
      4'h6: hex7 = 8'h41;
      4'h7: hex7 = 8'h1F;
      4'h8: hex7 = 8'h01;
      4'h9: hex7 = 8'h09;
      4'hA: hex7 = 8'h11;
      4'hB: hex7 = 8'hC1;
      4'hC: hex7 = 8'h63;
      4'hD: hex7 = 8'h85;
      4'hE: hex7 = 8'h61;
      default: hex7 = 8'h71;
    endcase
  endfunction

  assign tick = (cnt_q == CNT_MAX);

  always_comb begin
    case (bus.SW_in)
      2'b00:   begin left_byte = bus.curPC[7:0];     right_byte = bus.nextPC[7:0];    end
      2'b01:   begin left_byte = bus.rsData[7:0];    right_byte = bus.rtData[7:0];    end
      2'b10:   begin left_byte = bus.ALUresult[7:0]; right_byte = bus.DBdata[7:0];    end
      default: begin left_byte = bus.curPC[7:0];     right_byte = bus.ALUresult[7:0]; end
    endcase
  end

  // NOTE: every signal gets a default first so no path through this block infers a latch.
  always_comb begin
    cnt_d   = tick ? '0 : cnt_q + 1'b1;
    idx_d   = tick ? idx_q + 2'd1 : idx_q;
    sel_d   = sel_q;
    l_d     = l_q;
    r_d     = r_q;
    phase_d = phase_q;
    ctrl_d  = 4'b1111;
    seg_d   = 8'hFF;
    nibble  = 4'h0;

    if (tick && idx_q == 2'd3) begin
      sel_d = bus.SW_in;
      l_d   = left_byte;
      r_d   = right_byte;
    end

    if (tick) begin
      phase_d = PH_BLANK;
    end else if (phase_q == PH_BLANK && cnt_q == BLANK_END) begin
      phase_d = PH_SHOW;
    end

    // A tick always forces BLANK, so in SHOW idx_q already names the digit being driven.
    if (phase_d == PH_SHOW) begin
      case (idx_q)
        2'd0:    begin ctrl_d = 4'b1110; nibble = r_q[3:0]; end
        2'd1:    begin ctrl_d = 4'b1101; nibble = r_q[7:4]; end
        2'd2:    begin ctrl_d = 4'b1011; nibble = l_q[3:0]; end
        default: begin ctrl_d = 4'b0111; nibble = l_q[7:4]; end
      endcase
      seg_d = hex7(nibble);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      phase_q <= PH_WAIT;
      cnt_q   <= '0;
      idx_q   <= 2'd3;
      sel_q   <= 2'b00;
      l_q     <= 8'h00;
      r_q     <= 8'h00;
      ctrl_q  <= 4'b1111;
      seg_q   <= 8'hFF;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      l_q     <= l_d;
      r_q     <= r_d;
      ctrl_q  <= ctrl_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.ctrlBits = ctrl_q;
  assign bus.dispcode = seg_q;

endmodule
